branch_resolve_unit: RTL

Parametrised, pipelined branch/jump resolution unit for the out-of-order core's branch execution port. It accepts one issued control-flow op per cycle from the branch reservation station over a valid/ready handshake. It evaluates the condition, computes the target and link value, and compares both against the front-end prediction. Results, tagged with the ROB index, are returned to the CDB/ROB arbiter after a configurable pipeline latency, with full-pipeline flush on ROB recovery.

---
 rtl/branch_resolve_unit_if.sv | 44 ++++
 rtl/branch_resolve_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_resolve_unit_if : issue and result handshake bundle for the BRU
// Rev 1.0
// ---------------------------------------------------------------------------
interface branch_resolve_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ROB_IDX_W  = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_kind;
  logic [2:0]            in_cmpop;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [DATA_WIDTH-1:0] in_imm;
  logic                  in_pred_taken;
  logic [DATA_WIDTH-1:0] in_pred_target;
  logic [ROB_IDX_W-1:0]  in_rob_idx;

  logic                  out_valid;
  logic                  out_ready;
  logic                  out_taken;
  logic [DATA_WIDTH-1:0] out_next_pc;
  logic [DATA_WIDTH-1:0] out_link;
  logic                  out_mispredict;
  logic [ROB_IDX_W-1:0]  out_rob_idx;

  modport master (
    output in_valid, in_kind, in_cmpop, in_a, in_b, in_pc, in_imm,
           in_pred_taken, in_pred_target, in_rob_idx, out_ready,
    input  in_ready, out_valid, out_taken, out_next_pc, out_link,
           out_mispredict, out_rob_idx
  );

  modport slave (
    input  in_valid, in_kind, in_cmpop, in_a, in_b, in_pc, in_imm,
           in_pred_taken, in_pred_target, in_rob_idx, out_ready,
    output in_ready, out_valid, out_taken, out_next_pc, out_link,
           out_mispredict, out_rob_idx
  );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_resolve_unit : pipelined branch/jump resolution with ROB flush.
// Optional BRU_PERF_CNT_EN adds transfer / mispredict counters.
// Rev 1.0
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int ROB_IDX_W   = 5,
  parameter int PIPE_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
`ifdef BRU_PERF_CNT_EN
  input  logic                  stats_clear,
  output logic [31:0]           br_count,
  output logic [31:0]           mispred_count,
`endif
  branch_resolve_unit_if.slave  bus
);

  generate
    if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_stages
      $error("branch_resolve_unit: PIPE_STAGES must be 1..3");
    end
  endgenerate

  localparam int              LAST       = PIPE_STAGES - 1;
  localparam logic [1:0]      c_KIND_BR  = 2'd0;
  localparam logic [1:0]      c_KIND_JAL = 2'd1;
  localparam logic [1:0]      c_KIND_JR  = 2'd2;
  localparam logic [DATA_WIDTH-1:0] c_LSB_CLR = {{(DATA_WIDTH-1){1'b1}}, 1'b0};

  logic                  w_cond;
  logic                  w_taken;
  logic                  w_mis;
  logic [DATA_WIDTH-1:0] w_pc_tgt;
  logic [DATA_WIDTH-1:0] w_jalr_sum;
  logic [DATA_WIDTH-1:0] w_tgt;
  logic [DATA_WIDTH-1:0] w_link;
  logic [DATA_WIDTH-1:0] w_next_pc;

  always_comb begin
    w_cond = 1'b0;
    case (bus.in_cmpop)
      3'b000:  w_cond = (bus.in_a == bus.in_b);
      3'b001:  w_cond = (bus.in_a != bus.in_b);
      3'b100:  w_cond = ($signed(bus.in_a) <  $signed(bus.in_b));
      3'b101:  w_cond = ($signed(bus.in_a) >= $signed(bus.in_b));
      3'b110:  w_cond = (bus.in_a <  bus.in_b);
      3'b111:  w_cond = (bus.in_a >= bus.in_b);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_pc_tgt   = bus.in_pc + bus.in_imm;
  assign w_jalr_sum = bus.in_a + bus.in_imm;
  assign w_tgt      = (bus.in_kind == c_KIND_JR) ? (w_jalr_sum & c_LSB_CLR) : w_pc_tgt;
  assign w_link     = bus.in_pc + DATA_WIDTH'(4);
  // Kind 3 (illegal) falls through to not-taken.
  assign w_taken    = (bus.in_kind == c_KIND_JAL) | (bus.in_kind == c_KIND_JR) |
                      ((bus.in_kind == c_KIND_BR) & w_cond);
  assign w_next_pc  = w_taken ? w_tgt : w_link;
  assign w_mis      = (w_taken != bus.in_pred_taken) |
                      (w_taken & (w_tgt != bus.in_pred_target));

  logic [PIPE_STAGES-1:0] r_vld;
  logic [PIPE_STAGES-1:0] r_taken;
  logic [PIPE_STAGES-1:0] r_mis;
  logic [DATA_WIDTH-1:0]  r_next_pc [PIPE_STAGES];
  logic [DATA_WIDTH-1:0]  r_link    [PIPE_STAGES];
  logic [ROB_IDX_W-1:0]   r_rob     [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] w_adv;
  logic                   w_load0;

  // Advance chain runs back from the output so a full pipe drains and refills in one cycle.
  always_comb begin
    logic [PIPE_STAGES-1:0] v_adv;
    v_adv       = '0;
    v_adv[LAST] = r_vld[LAST] & bus.out_ready & ~flush;
    for (int k = LAST - 1; k >= 0; k--) begin
      v_adv[k] = r_vld[k] & (~r_vld[k+1] | v_adv[k+1]);
    end
    w_adv = v_adv;
  end

  assign bus.in_ready = ~r_vld[0] | w_adv[0];
  assign w_load0      = bus.in_valid & bus.in_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= '0;
      r_taken <= '0;
      r_mis   <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        r_next_pc[k] <= '0;
        r_link[k]    <= '0;
        r_rob[k]     <= '0;
      end
    end else begin
      if (flush) begin
        r_vld <= '0;
      end else begin
        r_vld[0] <= w_load0 | (r_vld[0] & ~w_adv[0]);
        for (int k = 1; k < PIPE_STAGES; k++) begin
          r_vld[k] <= w_adv[k-1] | (r_vld[k] & ~w_adv[k]);
        end
      end
      if (w_load0) begin
        r_taken[0]   <= w_taken;
        r_mis[0]     <= w_mis;
        r_next_pc[0] <= w_next_pc;
        r_link[0]    <= w_link;
        r_rob[0]     <= bus.in_rob_idx;
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
        if (w_adv[k-1]) begin
          r_taken[k]   <= r_taken[k-1];
          r_mis[k]     <= r_mis[k-1];
          r_next_pc[k] <= r_next_pc[k-1];
          r_link[k]    <= r_link[k-1];
          r_rob[k]     <= r_rob[k-1];
        end
      end
    end
  end

  assign bus.out_valid      = r_vld[LAST] & ~flush;
  assign bus.out_taken      = r_taken[LAST];
  assign bus.out_mispredict = r_mis[LAST];
  assign bus.out_next_pc    = r_next_pc[LAST];
  assign bus.out_link       = r_link[LAST];
  assign bus.out_rob_idx    = r_rob[LAST];

`ifdef BRU_PERF_CNT_EN
  logic        w_out_xfer;
  logic [31:0] r_br_cnt;
  logic [31:0] r_mis_cnt;

  assign w_out_xfer = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else if (stats_clear) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else if (w_out_xfer) begin
      r_br_cnt <= r_br_cnt + 32'd1;
      if (r_mis[LAST]) begin
        r_mis_cnt <= r_mis_cnt + 32'd1;
      end
    end
  end

  assign br_count      = r_br_cnt;
  assign mispred_count = r_mis_cnt;
`endif

endmodule
`default_nettype wire
